// File: rtl/mcp_formulation_fifo_l_pkg.sv
// Shared types for the launch-side MCP crossing.
// FSM encoding and the bit that marks the BUSY state.
package mcp_pkg;

  typedef enum logic [0:0] {
    FSM_IDLE,
    FSM_BUSY
  } mcp_l_fsm_t;

  localparam int B_FSM_BUSY = 0;

endpackage

// File: rtl/mcp_formulation_fifo_l_if.sv
// Producer handshake into the launch FIFO.
// The master drives valid/data, the slave returns ready.
interface mcp_formulation_fifo_l_if #(
  parameter int W = 32
);

  logic         l_in_valid;
  logic [W-1:0] l_in_data;
  logic         l_in_ready;

  modport master (
    output l_in_valid,
    output l_in_data,
    input  l_in_ready
  );

  modport slave (
    input  l_in_valid,
    input  l_in_data,
    output l_in_ready
  );

endinterface

// File: rtl/mcp_formulation_fifo_l_sync_ff_n.sv
// N-stage flop chain bringing an async level into clk.
// Resets low so an idle toggle reads as 0.
module sync_ff_n #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [N-1:0] sr;

  // shift the async input through N flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sr <= '0;
    else        sr <= {sr[N-2:0], d};
  end

  assign q = sr[N-1];

endmodule

// File: rtl/mcp_formulation_fifo_l.sv
// Launch half of an MCP crossing: FIFO plus toggle req/ack.
// Data on sync_l_out_r is held until the ack catches up.
module mcp_formulation_fifo_l
  import mcp_pkg::*;
#(
  parameter int W      = 32,
  parameter int D      = 4,
  parameter int SYNC_N = 2
) (
  input  logic                l_clk,
  input  logic                l_rst_n,
  mcp_formulation_fifo_l_if.slave in_if,
  output logic [$clog2(D):0]  l_level_r,
  output logic                l_busy_r,
  output logic                l_err_r,
  input  logic                sync_c_ack_tgl_r,
  output logic [W-1:0]        sync_l_out_r,
  output logic                sync_l_req_tgl_r
);

  localparam int AW = $clog2(D);
  localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

  logic [W-1:0] mem [D];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  mcp_l_fsm_t   state;
  mcp_l_fsm_t   state_nx;
  logic         ack_s;
  logic         done;
  logic         empty;
  logic         full;
  logic         push;
  logic         pop;

  sync_ff_n #(.N(SYNC_N)) u_ack_sync (
    .clk   (l_clk),
    .rst_n (l_rst_n),
    .d     (sync_c_ack_tgl_r),
    .q     (ack_s)
  );

  assign full  = (wr_ptr[AW] != rd_ptr[AW])
              && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign done  = (ack_s == sync_l_req_tgl_r);

  assign in_if.l_in_ready = !full;
  assign push = in_if.l_in_valid && !full;
  assign l_busy_r = state[B_FSM_BUSY];

  // launch decision: pop head when idle or when previous word done
  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    unique case (state)
      FSM_IDLE: begin
        if (!empty) begin
          pop      = 1'b1;
          state_nx = FSM_BUSY;
        end
      end
      FSM_BUSY: begin
        if (done) begin
          if (!empty) pop = 1'b1;
          else        state_nx = FSM_IDLE;
        end
      end
      default: state_nx = FSM_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge l_clk or negedge l_rst_n) begin
    if (!l_rst_n) state <= FSM_IDLE;
    else          state <= state_nx;
  end

  // storage is not reset; pointers alone define what is valid
  always_ff @(posedge l_clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= in_if.l_in_data;
  end

  // pointers and occupancy
  always_ff @(posedge l_clk or negedge l_rst_n) begin
    if (!l_rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      l_level_r <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ONE;
      if (pop)  rd_ptr <= rd_ptr + ONE;
      case ({push, pop})
        2'b10:   l_level_r <= l_level_r + ONE;
        2'b01:   l_level_r <= l_level_r - ONE;
        default: l_level_r <= l_level_r;
      endcase
    end
  end

  // crossing data and req toggle move together on each launch
  always_ff @(posedge l_clk or negedge l_rst_n) begin
    if (!l_rst_n) begin
      sync_l_out_r     <= '0;
      sync_l_req_tgl_r <= 1'b0;
    end else if (pop) begin
      sync_l_out_r     <= mem[rd_ptr[AW-1:0]];
      sync_l_req_tgl_r <= ~sync_l_req_tgl_r;
    end
  end

  // sticky flag for an ack toggle seen with nothing in flight
  always_ff @(posedge l_clk or negedge l_rst_n) begin
    if (!l_rst_n) begin
      l_err_r <= 1'b0;
    end else if (state == FSM_IDLE && ack_s != sync_l_req_tgl_r) begin
      l_err_r <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mcp_formulation_fifo_l.sv
// Directed bench for the launch-side MCP FIFO.
// Capture side is a small ack model with adjustable delay.
module tb_mcp_formulation_fifo_l;

  localparam int W = 32;
  localparam int D = 4;
  localparam int SYNC_N = 2;

  logic        l_clk = 1'b0;
  logic        l_rst_n = 1'b0;
  logic [2:0]  l_level_r;
  logic        l_busy_r;
  logic        l_err_r;
  logic        ack_tgl = 1'b0;
  logic [31:0] out;
  logic        req;

  int vecs = 0;
  int miss = 0;

  mcp_formulation_fifo_l_if #(.W(W)) in_if ();

  mcp_formulation_fifo_l #(.W(W), .D(D), .SYNC_N(SYNC_N)) dut (
    .l_clk            (l_clk),
    .l_rst_n          (l_rst_n),
    .in_if            (in_if),
    .l_level_r        (l_level_r),
    .l_busy_r         (l_busy_r),
    .l_err_r          (l_err_r),
    .sync_c_ack_tgl_r (ack_tgl),
    .sync_l_out_r     (out),
    .sync_l_req_tgl_r (req)
  );

  always #5 l_clk = ~l_clk;

  // capture-side model: echo req back after ack_dly cycles
  bit ack_en = 0;
  bit ack_flip = 0;
  int ack_dly = 0;
  int ack_cnt = 0;
  always @(posedge l_clk or negedge l_rst_n) begin
    if (!l_rst_n) begin
      ack_tgl <= 1'b0;
      ack_cnt <= 0;
    end else if (ack_flip) begin
      ack_tgl <= ~ack_tgl;
    end else if (ack_en && req != ack_tgl) begin
      if (ack_cnt >= ack_dly) begin
        ack_tgl <= req;
        ack_cnt <= 0;
      end else begin
        ack_cnt <= ack_cnt + 1;
      end
    end else begin
      ack_cnt <= 0;
    end
  end

  // monitor: log each launched word and count busy falls
  logic [31:0] launched[$];
  int   falls = 0;
  logic prev_req = 1'b0;
  logic prev_busy = 1'b0;
  always @(negedge l_clk) begin
    if (l_rst_n && req !== prev_req) launched.push_back(out);
    if (prev_busy && !l_busy_r) falls = falls + 1;
    prev_req  = req;
    prev_busy = l_busy_r;
  end

  task automatic tick();
    @(posedge l_clk);
    #1;
  endtask

  task automatic push(input logic [31:0] v, input string nm);
    bit acc = 0;
    int n = 0;
    in_if.l_in_valid = 1'b1;
    in_if.l_in_data  = v;
    while (!acc && n < 100) begin
      acc = in_if.l_in_ready;
      tick();
      n++;
    end
    in_if.l_in_valid = 1'b0;
    vecs++;
    if (!acc) begin
      miss++;
      $display("FAIL %s_push accepted=0 want 1", nm);
    end
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while ((l_busy_r || l_level_r != 0) && n < 300) begin
      tick();
      n++;
    end
    vecs++;
    if (l_busy_r || l_level_r != 0) begin
      miss++;
      $display("FAIL %s_idle busy=%0d level=%0d want 0 0",
               nm, l_busy_r, l_level_r);
    end
  endtask

  task automatic check_reset_vals(input string nm);
    vecs++;
    if (l_level_r !== 3'd0) begin
      miss++;
      $display("FAIL %s_level got %0d want 0", nm, l_level_r);
    end
    vecs++;
    if (req !== 1'b0) begin
      miss++;
      $display("FAIL %s_req got %b want 0", nm, req);
    end
    vecs++;
    if (out !== 32'h0) begin
      miss++;
      $display("FAIL %s_data got %h want 0", nm, out);
    end
    vecs++;
    if (l_busy_r !== 1'b0 || l_err_r !== 1'b0) begin
      miss++;
      $display("FAIL %s_flags busy=%b err=%b want 0 0",
               nm, l_busy_r, l_err_r);
    end
    vecs++;
    if (in_if.l_in_ready !== 1'b1) begin
      miss++;
      $display("FAIL %s_ready got %b want 1", nm, in_if.l_in_ready);
    end
  endtask

  task automatic test_reset();
    in_if.l_in_valid = 1'b0;
    in_if.l_in_data  = '0;
    repeat (3) tick();
    l_rst_n = 1'b1;
    tick();
    check_reset_vals("reset");
  endtask

  task automatic test_single();
    int t = 0;
    int t_ack = -1;
    ack_en = 1;
    ack_dly = 3;
    in_if.l_in_valid = 1'b1;
    in_if.l_in_data  = 32'hDEADBEEF;
    tick();
    in_if.l_in_valid = 1'b0;
    vecs++;
    if (l_level_r !== 3'd1 || req !== 1'b0) begin
      miss++;
      $display("FAIL single_queued level=%0d req=%b want 1 0",
               l_level_r, req);
    end
    tick();
    vecs++;
    if (out !== 32'hDEADBEEF || req !== 1'b1) begin
      miss++;
      $display("FAIL single_launch data=%h req=%b want deadbeef 1",
               out, req);
    end
    vecs++;
    if (l_busy_r !== 1'b1 || l_level_r !== 3'd0) begin
      miss++;
      $display("FAIL single_busy busy=%b level=%0d want 1 0",
               l_busy_r, l_level_r);
    end
    while (l_busy_r && t < 50) begin
      tick();
      t++;
      if (t_ack < 0 && ack_tgl) t_ack = t;
    end
    vecs++;
    if (l_busy_r !== 1'b0 || t_ack < 0 || t - t_ack != SYNC_N + 1) begin
      miss++;
      $display("FAIL single_ack_to_idle got %0d cycles want %0d",
               t - t_ack, SYNC_N + 1);
    end
  endtask

  task automatic test_fill();
    logic [31:0] w [6];
    int  acc_n = 0;
    int  n = 0;
    bit  a;
    bit  bad = 0;
    w = '{32'hF0, 32'hF1, 32'hF2, 32'hF3, 32'hF4, 32'hF5};
    ack_en = 0;
    launched.delete();
    in_if.l_in_valid = 1'b1;
    while (acc_n < 5 && n < 20) begin
      in_if.l_in_data = w[acc_n];
      a = in_if.l_in_ready;
      tick();
      n++;
      if (a) acc_n++;
    end
    in_if.l_in_data = w[5];
    vecs++;
    if (l_level_r !== 3'd4 || in_if.l_in_ready !== 1'b0) begin
      miss++;
      $display("FAIL fill_full level=%0d ready=%b want 4 0",
               l_level_r, in_if.l_in_ready);
    end
    vecs++;
    if (out !== 32'hF0 || launched.size() != 1) begin
      miss++;
      $display("FAIL fill_inflight data=%h n=%0d want f0 1",
               out, launched.size());
    end
    tick();
    vecs++;
    if (l_level_r !== 3'd4) begin
      miss++;
      $display("FAIL fill_refuse level=%0d want 4", l_level_r);
    end
    ack_en = 1;
    ack_dly = 0;
    a = 0;
    n = 0;
    while (!a && n < 50) begin
      a = in_if.l_in_ready;
      tick();
      n++;
    end
    in_if.l_in_valid = 1'b0;
    vecs++;
    if (!a || launched.size() != 2 || l_level_r !== 3'd4) begin
      miss++;
      $display("FAIL fill_sixth acc=%b n=%0d level=%0d want 1 2 4",
               a, launched.size(), l_level_r);
    end
    wait_idle("fill");
    for (int i = 0; i < 6; i++)
      if (i >= launched.size() || launched[i] !== w[i]) bad = 1;
    vecs++;
    if (bad || launched.size() != 6) begin
      miss++;
      $display("FAIL fill_order n=%0d want 6 in order f0..f5",
               launched.size());
    end
  endtask

  task automatic test_back_to_back();
    ack_en = 1;
    ack_dly = 0;
    tick();
    launched.delete();
    falls = 0;
    for (int i = 1; i <= 4; i++) push(32'(i), "b2b");
    wait_idle("b2b");
    tick();
    vecs++;
    if (launched.size() != 4) begin
      miss++;
      $display("FAIL b2b_flips got %0d want 4", launched.size());
    end
    for (int i = 0; i < 4 && i < launched.size(); i++) begin
      vecs++;
      if (launched[i] !== 32'(i + 1)) begin
        miss++;
        $display("FAIL b2b_word%0d got %h want %h",
                 i, launched[i], i + 1);
      end
    end
    vecs++;
    if (falls != 1) begin
      miss++;
      $display("FAIL b2b_busy_falls got %0d want 1", falls);
    end
  endtask

  task automatic test_full_pop();
    logic [31:0] w [6];
    logic r;
    bit   a;
    bit   hit = 0;
    bit   bad = 0;
    int   n = 0;
    w = '{32'hC0, 32'hC1, 32'hC2, 32'hC3, 32'hC4, 32'hC5};
    ack_en = 0;
    launched.delete();
    for (int i = 0; i < 5; i++) push(w[i], "fp");
    vecs++;
    if (l_level_r !== 3'd4) begin
      miss++;
      $display("FAIL fp_full level=%0d want 4", l_level_r);
    end
    in_if.l_in_valid = 1'b1;
    in_if.l_in_data  = w[5];
    ack_en = 1;
    ack_dly = 2;
    while (!hit && n < 50) begin
      r = req;
      a = in_if.l_in_ready;
      tick();
      n++;
      if (req != r) hit = 1;
    end
    vecs++;
    if (!hit || a || l_level_r !== 3'd3) begin
      miss++;
      $display("FAIL fp_refused pop=%b ready=%b level=%0d want 1 0 3",
               hit, a, l_level_r);
    end
    a = in_if.l_in_ready;
    tick();
    in_if.l_in_valid = 1'b0;
    vecs++;
    if (!a || l_level_r !== 3'd4) begin
      miss++;
      $display("FAIL fp_accept ready=%b level=%0d want 1 4",
               a, l_level_r);
    end
    wait_idle("fp");
    for (int i = 0; i < 6; i++)
      if (i >= launched.size() || launched[i] !== w[i]) bad = 1;
    vecs++;
    if (bad || launched.size() != 6) begin
      miss++;
      $display("FAIL fp_order n=%0d want 6 in order c0..c5",
               launched.size());
    end
  endtask

  task automatic test_stray();
    logic r;
    ack_en = 0;
    tick();
    vecs++;
    if (l_err_r !== 1'b0) begin
      miss++;
      $display("FAIL stray_pre err=%b want 0", l_err_r);
    end
    ack_flip = 1;
    tick();
    ack_flip = 0;
    tick();
    vecs++;
    if (l_err_r !== 1'b0) begin
      miss++;
      $display("FAIL stray_early err=%b want 0", l_err_r);
    end
    tick();
    tick();
    vecs++;
    if (l_err_r !== 1'b1) begin
      miss++;
      $display("FAIL stray_set err=%b want 1", l_err_r);
    end
    repeat (5) tick();
    vecs++;
    if (l_err_r !== 1'b1) begin
      miss++;
      $display("FAIL stray_sticky err=%b want 1", l_err_r);
    end
    r = req;
    push(32'hA5, "stray");
    tick();
    vecs++;
    if (out !== 32'hA5 || req !== ~r) begin
      miss++;
      $display("FAIL stray_launch data=%h req=%b want a5 %b",
               out, req, ~r);
    end
    wait_idle("stray");
    vecs++;
    if (l_err_r !== 1'b1) begin
      miss++;
      $display("FAIL stray_hold err=%b want 1", l_err_r);
    end
  endtask

  task automatic test_reset_mid();
    ack_en = 0;
    for (int i = 0; i < 4; i++) push(32'h100 + 32'(i), "rm");
    vecs++;
    if (l_level_r !== 3'd3 || l_busy_r !== 1'b1) begin
      miss++;
      $display("FAIL rm_loaded level=%0d busy=%b want 3 1",
               l_level_r, l_busy_r);
    end
    #2;
    l_rst_n = 1'b0;
    #1;
    check_reset_vals("rm_async");
    repeat (2) tick();
    l_rst_n = 1'b1;
    launched.delete();
    tick();
    push(32'h5A5A5A5A, "rm");
    vecs++;
    if (req !== 1'b0 || l_level_r !== 3'd1) begin
      miss++;
      $display("FAIL rm_queued req=%b level=%0d want 0 1",
               req, l_level_r);
    end
    tick();
    vecs++;
    if (req !== 1'b1 || out !== 32'h5A5A5A5A) begin
      miss++;
      $display("FAIL rm_launch req=%b data=%h want 1 5a5a5a5a",
               req, out);
    end
    ack_en = 1;
    wait_idle("rm");
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
    test_full_pop();
    test_stray();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
